id_stage: RTL
=============

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have parameter NOP_INSTR, default 32'h0000_0000, instruction word decoded as a bubble.
REQ-002 SHALL have ports: clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 if_id_instruction  in  32  and  if_id_pc_next  in  32  IF/ID register contents.
REQ-005 wb_reg_write  in  1,  wb_write_addr  in  5,  wb_write_data  in  32  writeback port.
REQ-006 ex_mem_reg_write  in  1,  ex_mem_mem_read  in  1,  ex_mem_write_addr  in  5,  ex_mem_alu_result  in  32  EX/MEM state for branch forwarding.
REQ-007 stall  out  1,  flush_if  out  1,  jump_taken  out  1,  branch_taken  out  1,  pc_jump  out  32,  pc_branch  out  32  fetch control (combinational).
REQ-008 id_ex_pc_next, id_ex_rs_data, id_ex_rt_data, id_ex_imm  out  32 each;  id_ex_rs, id_ex_rt, id_ex_write_addr  out  5 each;  id_ex_alu_op  out  4;  id_ex_alu_src, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg, id_ex_reg_write  out  1 each  ID/EX register.

Function
REQ-009 SHALL decode: R-type (op 00) funct 20 add, 22 sub, 24 and, 25 or, 2a slt; op 08 addi, 0c andi, 0d ori, 23 lw, 2b sw, 04 beq, 05 bne, 02 j.
REQ-010 alu_op encoding SHALL be add 0, sub 1, and 2, or 3, slt 4; lw/sw/addi use add; beq/bne use sub.
REQ-011 Any other opcode/funct, and NOP_INSTR, SHALL produce bubble controls (all id_ex control bits 0, alu_op 0).
REQ-012 Immediate: andi/ori zero-extend, all others sign-extend imm[15:0] to 32 bits.
REQ-013 Destination: rd for R-type, rt for addi/andi/ori/lw, 0 otherwise.
REQ-014 Register file: 32x32 internal; $0 reads 0 always; write at posedge clk when wb_reg_write and wb_write_addr!=0.
REQ-015 Read of a register written by WB in the same cycle SHALL return wb_write_data (write-through bypass).
REQ-016 Branch comparator operand SHALL be ex_mem_alu_result when ex_mem_reg_write, !ex_mem_mem_read, ex_mem_write_addr!=0 and matches the source; else register-file value (with REQ-015 bypass).
REQ-017 pc_branch = if_id_pc_next + (sign_ext(imm)<<2), mod 2^32; pc_jump = {if_id_pc_next[31:28], instr[25:0], 2'b00}.
REQ-018 stall SHALL assert when: (a) id_ex_mem_read, id_ex_write_addr!=0, and it matches a source read by the current instruction; (b) current is beq/bne, id_ex_reg_write, id_ex_write_addr!=0 matches rs or rt; (c) current is beq/bne, ex_mem_mem_read, ex_mem_write_addr!=0 matches rs or rt.
REQ-019 Sources read: rs for all except j; rt additionally for R-type, sw, beq, bne.
REQ-020 jump_taken = (op j) and !stall; branch_taken = (beq equal or bne unequal) and !stall.
REQ-021 flush_if = jump_taken | branch_taken; stall and flush_if SHALL never assert together.
REQ-022 ID/EX register SHALL update every posedge clk; on stall it SHALL load bubble controls (data fields don't-care); otherwise decoded values, id_ex_pc_next <= if_id_pc_next.
REQ-023 Branch/jump instructions themselves SHALL enter ID/EX as bubbles (no write, no memory access).

Reset
REQ-024 While rst_n=0, all id_ex_* outputs SHALL be 0 and all 32 registers SHALL be 0, asynchronously.
REQ-025 After reset with if_id_instruction=0: stall, flush_if, jump_taken, branch_taken SHALL be 0.
REQ-026 Reset asserted mid-stall SHALL clear ID/EX immediately; no pending stall state is retained.

Verification
REQ-027 WB writes $8=0x0000_0005 same cycle ID reads add $9,$8,$8 -> id_ex_rs_data=id_ex_rt_data=5, alu_op 0, write_addr 9, reg_write 1.
REQ-028 lw $8,0($0) in ID, then add $9,$8,$0 -> stall=1 one cycle, ID/EX bubble, add issued next cycle with stall=0.
REQ-029 beq $1,$2,+3 with $1=$2=7, if_id_pc_next=0x100 -> branch_taken=1, flush_if=1, pc_branch=0x10C, ID/EX bubble.
REQ-030 j 0x0000040 with if_id_pc_next=0x9000_0004 -> jump_taken=1, pc_jump=0x9000_0100.
REQ-031 addi $3,$0,1 in EX then bne $3,$0,-1 -> stall one cycle, next cycle forwards ex_mem_alu_result=1, branch_taken=1, pc_branch=if_id_pc_next-4.
REQ-032 Write to $0 with 0xFFFF_FFFF then read $0 -> 0; andi imm 0x8000 -> id_ex_imm=0x0000_8000, addi imm 0x8000 -> 0xFFFF_8000.

Source files
------------

// File: rtl/id_stage.sv
// Instruction decode stage: instruction decode, 32x32 register file with write-through,
// early branch/jump resolution, load-use and branch hazard detection, and the ID/EX register.
module id_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_id_instruction,
    input  logic [31:0] if_id_pc_next,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_write_addr,
    input  logic [31:0] wb_write_data,
    input  logic        ex_mem_reg_write,
    input  logic        ex_mem_mem_read,
    input  logic [4:0]  ex_mem_write_addr,
    input  logic [31:0] ex_mem_alu_result,
    output logic        stall,
    output logic        flush_if,
    output logic        jump_taken,
    output logic        branch_taken,
    output logic [31:0] pc_jump,
    output logic [31:0] pc_branch,
    output logic [31:0] id_ex_pc_next,
    output logic [31:0] id_ex_rs_data,
    output logic [31:0] id_ex_rt_data,
    output logic [31:0] id_ex_imm,
    output logic [4:0]  id_ex_rs,
    output logic [4:0]  id_ex_rt,
    output logic [4:0]  id_ex_write_addr,
    output logic [3:0]  id_ex_alu_op,
    output logic        id_ex_alu_src,
    output logic        id_ex_mem_read,
    output logic        id_ex_mem_write,
    output logic        id_ex_mem_to_reg,
    output logic        id_ex_reg_write
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2a;

    typedef enum logic [3:0] {
        K_BUBBLE, K_ADD, K_SUB, K_AND, K_OR, K_SLT,
        K_ADDI, K_ANDI, K_ORI, K_LW, K_SW, K_BEQ, K_BNE, K_J
    } kind_t;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_SLT = 4'd4
    } alu_op_t;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm16;

    assign opcode = if_id_instruction[31:26];
    assign rs     = if_id_instruction[25:21];
    assign rt     = if_id_instruction[20:16];
    assign rd     = if_id_instruction[15:11];
    assign imm16  = if_id_instruction[15:0];
    assign funct  = if_id_instruction[5:0];

    kind_t kind;

    always_comb begin
        kind = K_BUBBLE;
        if (if_id_instruction != NOP_INSTR) begin
            case (opcode)
                OP_RTYPE: begin
                    case (funct)
                        FN_ADD:  kind = K_ADD;
                        FN_SUB:  kind = K_SUB;
                        FN_AND:  kind = K_AND;
                        FN_OR:   kind = K_OR;
                        FN_SLT:  kind = K_SLT;
                        default: kind = K_BUBBLE;
                    endcase
                end
                OP_ADDI: kind = K_ADDI;
                OP_ANDI: kind = K_ANDI;
                OP_ORI:  kind = K_ORI;
                OP_LW:   kind = K_LW;
                OP_SW:   kind = K_SW;
                OP_BEQ:  kind = K_BEQ;
                OP_BNE:  kind = K_BNE;
                OP_J:    kind = K_J;
                default: kind = K_BUBBLE;
            endcase
        end
    end

    alu_op_t    dec_alu_op;
    logic       dec_alu_src;
    logic       dec_mem_read;
    logic       dec_mem_write;
    logic       dec_mem_to_reg;
    logic       dec_reg_write;
    logic [4:0] dec_write_addr;
    logic       uses_rs;
    logic       uses_rt;
    logic       is_beq;
    logic       is_bne;
    logic       is_j;
    logic       imm_zext;

    always_comb begin
        dec_alu_op     = ALU_ADD;
        dec_alu_src    = 1'b0;
        dec_mem_read   = 1'b0;
        dec_mem_write  = 1'b0;
        dec_mem_to_reg = 1'b0;
        dec_reg_write  = 1'b0;
        dec_write_addr = '0;
        uses_rs        = 1'b0;
        uses_rt        = 1'b0;
        is_beq         = 1'b0;
        is_bne         = 1'b0;
        is_j           = 1'b0;
        imm_zext       = 1'b0;
        case (kind)
            K_ADD, K_SUB, K_AND, K_OR, K_SLT: begin
                dec_reg_write  = 1'b1;
                dec_write_addr = rd;
                uses_rs        = 1'b1;
                uses_rt        = 1'b1;
                case (kind)
                    K_SUB:   dec_alu_op = ALU_SUB;
                    K_AND:   dec_alu_op = ALU_AND;
                    K_OR:    dec_alu_op = ALU_OR;
                    K_SLT:   dec_alu_op = ALU_SLT;
                    default: dec_alu_op = ALU_ADD;
                endcase
            end
            K_ADDI, K_ANDI, K_ORI: begin
                dec_reg_write  = 1'b1;
                dec_write_addr = rt;
                dec_alu_src    = 1'b1;
                uses_rs        = 1'b1;
                imm_zext       = (kind != K_ADDI);
                if (kind == K_ANDI)
                    dec_alu_op = ALU_AND;
                else if (kind == K_ORI)
                    dec_alu_op = ALU_OR;
            end
            K_LW: begin
                dec_reg_write  = 1'b1;
                dec_write_addr = rt;
                dec_alu_src    = 1'b1;
                dec_mem_read   = 1'b1;
                dec_mem_to_reg = 1'b1;
                uses_rs        = 1'b1;
            end
            K_SW: begin
                dec_alu_src   = 1'b1;
                dec_mem_write = 1'b1;
                uses_rs       = 1'b1;
                uses_rt       = 1'b1;
            end
            K_BEQ, K_BNE: begin
                dec_alu_op = ALU_SUB;
                uses_rs    = 1'b1;
                uses_rt    = 1'b1;
                is_beq     = (kind == K_BEQ);
                is_bne     = (kind == K_BNE);
            end
            K_J:     is_j = 1'b1;
            default: ;
        endcase
    end

    logic [31:0] imm_sext;
    logic [31:0] imm_ext;

    assign imm_sext = {{16{imm16[15]}}, imm16};
    assign imm_ext  = imm_zext ? {16'h0000, imm16} : imm_sext;

    logic [31:0] regs [32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            regs <= '{default: '0};
        else if (wb_reg_write && wb_write_addr != '0)
            regs[wb_write_addr] <= wb_write_data;
    end

    // A same-cycle WB write is visible to the reader, so WB->ID needs no extra stall.
    logic [31:0] rs_rf;
    logic [31:0] rt_rf;

    always_comb begin
        rs_rf = '0;
        if (rs != '0)
            rs_rf = (wb_reg_write && wb_write_addr == rs) ? wb_write_data : regs[rs];
    end

    always_comb begin
        rt_rf = '0;
        if (rt != '0)
            rt_rf = (wb_reg_write && wb_write_addr == rt) ? wb_write_data : regs[rt];
    end

    logic        mem_fwd_ok;
    logic [31:0] br_a;
    logic [31:0] br_b;
    logic        operands_equal;

    assign mem_fwd_ok     = ex_mem_reg_write && !ex_mem_mem_read && ex_mem_write_addr != '0;
    assign br_a           = (mem_fwd_ok && ex_mem_write_addr == rs) ? ex_mem_alu_result : rs_rf;
    assign br_b           = (mem_fwd_ok && ex_mem_write_addr == rt) ? ex_mem_alu_result : rt_rf;
    assign operands_equal = (br_a == br_b);

    logic is_branch;
    logic load_use;
    logic br_after_ex;
    logic br_after_load;

    assign is_branch = is_beq | is_bne;

    assign load_use = id_ex_mem_read && id_ex_write_addr != '0 &&
                      ((uses_rs && id_ex_write_addr == rs) || (uses_rt && id_ex_write_addr == rt));

    assign br_after_ex = is_branch && id_ex_reg_write && id_ex_write_addr != '0 &&
                         (id_ex_write_addr == rs || id_ex_write_addr == rt);

    assign br_after_load = is_branch && ex_mem_mem_read && ex_mem_write_addr != '0 &&
                           (ex_mem_write_addr == rs || ex_mem_write_addr == rt);

    assign stall        = load_use | br_after_ex | br_after_load;
    assign jump_taken   = is_j && !stall;
    assign branch_taken = ((is_beq && operands_equal) || (is_bne && !operands_equal)) && !stall;
    assign flush_if     = jump_taken | branch_taken;

    assign pc_branch = if_id_pc_next + {imm_sext[29:0], 2'b00};
    assign pc_jump   = {if_id_pc_next[31:28], if_id_instruction[25:0], 2'b00};

    // Data fields load unconditionally; only controls are squashed for stalls and control transfers.
    logic issue_bubble;

    assign issue_bubble = stall | is_branch | is_j;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_ex_pc_next    <= '0;
            id_ex_rs_data    <= '0;
            id_ex_rt_data    <= '0;
            id_ex_imm        <= '0;
            id_ex_rs         <= '0;
            id_ex_rt         <= '0;
            id_ex_write_addr <= '0;
            id_ex_alu_op     <= '0;
            id_ex_alu_src    <= 1'b0;
            id_ex_mem_read   <= 1'b0;
            id_ex_mem_write  <= 1'b0;
            id_ex_mem_to_reg <= 1'b0;
            id_ex_reg_write  <= 1'b0;
        end else begin
            id_ex_pc_next <= if_id_pc_next;
            id_ex_rs_data <= rs_rf;
            id_ex_rt_data <= rt_rf;
            id_ex_imm     <= imm_ext;
            id_ex_rs      <= rs;
            id_ex_rt      <= rt;
            if (issue_bubble) begin
                id_ex_write_addr <= '0;
                id_ex_alu_op     <= '0;
                id_ex_alu_src    <= 1'b0;
                id_ex_mem_read   <= 1'b0;
                id_ex_mem_write  <= 1'b0;
                id_ex_mem_to_reg <= 1'b0;
                id_ex_reg_write  <= 1'b0;
            end else begin
                id_ex_write_addr <= dec_write_addr;
                id_ex_alu_op     <= dec_alu_op;
                id_ex_alu_src    <= dec_alu_src;
                id_ex_mem_read   <= dec_mem_read;
                id_ex_mem_write  <= dec_mem_write;
                id_ex_mem_to_reg <= dec_mem_to_reg;
                id_ex_reg_write  <= dec_reg_write;
            end
        end
    end

endmodule
